insn_encoder: RTL and testbench
===============================

// Module: insn_encoder
// PURPOSE
//  Inverse of the instruction decoder/control unit: accepts symbolic instruction requests
//  (kind, ALU op, registers, immediate) and emits 32-bit RV32I instruction words.
//  Each word comes with a sequential word address, for the test-program loader and self-test
//  generator that fill instruction memory. Expands the LI pseudo-op into LUI+ADDI.
//  Valid/ready on both sides.
// PARAMETERS
//  ADDR_W     10  width of emitted word-address counter
//  BASE_ADDR  0   word address loaded on reset
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       async active-low reset
//  in_valid   in   1       request valid
//  in_ready   out  1       request accepted when in_valid&in_ready
//  in_kind    in   4       0 R,1 OP-IMM,2 LOAD,3 STORE,4 BRANCH,5 LUI,6 AUIPC,7 JAL,8 JALR,9 EBREAK,10 LI
//  in_alu     in   4       ALU code for R/OP-IMM: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//  in_funct3  in   3       width (LOAD/STORE) or condition (BRANCH)
//  in_rd      in   5       destination register
//  in_rs1     in   5       source 1
//  in_rs2     in   5       source 2
//  in_imm     in   32      immediate: byte offset for B/J, value for U (upper 20 bits used), LI full value
//  out_valid  out  1       out_insn/out_addr valid
//  out_ready  in   1       consumer accepts word
//  out_insn   out  32      encoded instruction
//  out_addr   out  ADDR_W  word address of out_insn
//  err        out  1       sticky: an illegal request was consumed
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, out_insn=0, out_addr=BASE_ADDR, err=0. Async assert mid-emission aborts pending words.
//  FSM states:
//   IDLE: in_ready=1.
//   EMIT: holds one word. in_ready=0.
//   EMIT_LI2: holds LUI; ADDI pending. in_ready=0.
//  Accept in IDLE at edge N:
//   - legal: out_valid=1 at N+1, state EMIT (or EMIT_LI2 for two-word LI).
//   - illegal: err<=1, no word emitted, out_addr unchanged, stay IDLE.
//  Output handshake: out_valid&out_ready at edge M consumes the word and increments out_addr by 1.
//   - EMIT -> IDLE at M; no new request is taken that cycle, so 1 bubble per request.
//   - EMIT_LI2 -> EMIT with the ADDI word at M.
//  out_addr wraps 2^ADDR_W-1 -> 0 silently.
//  out_insn and out_addr stay stable while out_valid=1 and out_ready=0.
//  Encodings use standard RV32I opcodes/formats.
//   - R: SUB/SRA set funct7=0100000, others 0.
//   - OP-IMM: imm[11:0].
//     - SLLI/SRLI/SRAI: shamt=imm[4:0]; funct7=0100000 for SRAI only.
//   - B/J: imm bit0 dropped. Range not checked except shifts.
//   - U: imm[31:12].
//   - JALR: funct3=000.
//   - EBREAK=0x00100073.
//  LI:
//   - single word when -2048<=imm<=2047: ADDI rd,x0,imm.
//   - otherwise two words: LUI rd,(imm+0x800)[31:12], then ADDI rd,rd,imm[11:0].
//   - imm[11:0]==0: LUI only.
//  Illegal requests (consumed, err set):
//   - kind>10
//   - R alu>9
//   - OP-IMM alu==1 or alu>9
//   - shift imm[31:5]!=0
//   - LOAD funct3 in {011,110,111}
//   - STORE funct3>010
//   - BRANCH funct3 in {010,011}
//  in_rs1/in_rs2 ignored where the format lacks them.
// TESTING
//  R ADD rd=3,rs1=1,rs2=2 -> out_insn=0x002081B3, out_addr=0, valid one cycle after accept.
//  OP-IMM SRA rd=2,rs1=2,imm=3 -> 0x40315113; SLL with imm=32 -> err=1, no out_valid.
//  LI rd=5,imm=0x12345FFF -> 0x123462B7 @0 then 0xFFF28293 @1; in_ready low until both consumed.
//  LI rd=1,imm=-5 -> single 0xFFB00093. EBREAK -> 0x00100073.
//  out_ready low 3 cycles mid-LI -> out_insn/out_addr stable, in_ready=0; ADDI follows release.
//  ADDR_W=2: 5 words -> addrs 0,1,2,3,0. rst_n low mid-LI2 -> out_valid=0, out_addr=0, err=0 immediately.

Source files
------------

// File: rtl/insn_encoder.sv
// Symbolic-request to RV32I instruction-word encoder with sequential word addresses.
// Expands LI into ADDI or LUI(+ADDI); illegal requests are consumed and latch a sticky error.
module insn_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [3:0]        in_alu,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_insn,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EMIT     = 2'd1;
    localparam logic [1:0] ST_EMIT_LI2 = 2'd2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic [2:0] alu_funct3(input logic [3:0] alu);
        case (alu)
            4'd0, 4'd1: alu_funct3 = 3'b000;
            4'd2:       alu_funct3 = 3'b111;
            4'd3:       alu_funct3 = 3'b110;
            4'd4:       alu_funct3 = 3'b100;
            4'd5:       alu_funct3 = 3'b001;
            4'd6, 4'd7: alu_funct3 = 3'b101;
            4'd8:       alu_funct3 = 3'b010;
            4'd9:       alu_funct3 = 3'b011;
            default:    alu_funct3 = 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        enc_i = {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        enc_u = {imm, rd, op};
    endfunction

    logic [1:0]        state_r, state_n_s;
    logic              valid_r, valid_n_s;
    logic [31:0]       insn_r, insn_n_s;
    logic [31:0]       pend_r, pend_n_s;
    logic [ADDR_W-1:0] addr_r, addr_n_s;
    logic              err_r, err_n_s;
    logic              ready_r;

    logic [31:0] word_s, pend_s;
    logic        two_s, illegal_s;
    logic [6:0]  f7_s;
    logic [2:0]  af3_s;
    logic [19:0] hi_s;
    logic        shift_s;

    // Encode the current request into one word (or LUI plus a pending ADDI) and flag illegal requests
    always_comb begin
        word_s    = 32'd0;
        pend_s    = 32'd0;
        two_s     = 1'b0;
        illegal_s = 1'b0;
        af3_s     = alu_funct3(in_alu);
        f7_s      = ((in_alu == 4'd1) || (in_alu == 4'd7)) ? 7'b0100000 : 7'b0000000;
        shift_s   = (in_alu == 4'd5) || (in_alu == 4'd6) || (in_alu == 4'd7);
        hi_s      = in_imm[31:12] + {19'd0, in_imm[11]};
        case (in_kind)
            4'd0: begin
                if (in_alu > 4'd9) illegal_s = 1'b1;
                else word_s = {f7_s, in_rs2, in_rs1, af3_s, in_rd, OP_R};
            end
            4'd1: begin
                if ((in_alu == 4'd1) || (in_alu > 4'd9)) illegal_s = 1'b1;
                else if (shift_s) begin
                    if (in_imm[31:5] != 27'd0) illegal_s = 1'b1;
                    else word_s = {f7_s, in_imm[4:0], in_rs1, af3_s, in_rd, OP_IMM};
                end
                else word_s = enc_i(in_imm[11:0], in_rs1, af3_s, in_rd, OP_IMM);
            end
            4'd2: begin
                if ((in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111))
                    illegal_s = 1'b1;
                else word_s = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD);
            end
            4'd3: begin
                if (in_funct3 > 3'b010) illegal_s = 1'b1;
                else word_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            end
            4'd4: begin
                if ((in_funct3 == 3'b010) || (in_funct3 == 3'b011)) illegal_s = 1'b1;
                else word_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            4'd5:  word_s = enc_u(in_imm[31:12], in_rd, OP_LUI);
            4'd6:  word_s = enc_u(in_imm[31:12], in_rd, OP_AUIPC);
            4'd7:  word_s = enc_u({in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12]}, in_rd, OP_JAL);
            4'd8:  word_s = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR);
            4'd9:  word_s = 32'h0010_0073;
            4'd10: begin
                // Values fitting a signed 12-bit immediate need no LUI; the upper part is rounded for ADDI's sign
                if (in_imm[31:11] == {21{in_imm[11]}})
                    word_s = enc_i(in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM);
                else begin
                    word_s = enc_u(hi_s, in_rd, OP_LUI);
                    pend_s = enc_i(in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM);
                    two_s  = (in_imm[11:0] != 12'd0);
                end
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state logic for the request/emit handshake FSM
    always_comb begin
        state_n_s = state_r;
        valid_n_s = valid_r;
        insn_n_s  = insn_r;
        pend_n_s  = pend_r;
        addr_n_s  = addr_r;
        err_n_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (illegal_s) err_n_s = 1'b1;
                    else begin
                        valid_n_s = 1'b1;
                        insn_n_s  = word_s;
                        pend_n_s  = pend_s;
                        state_n_s = two_s ? ST_EMIT_LI2 : ST_EMIT;
                    end
                end
                else state_n_s = ST_IDLE;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    valid_n_s = 1'b0;
                    addr_n_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_n_s = ST_IDLE;
                end
                else state_n_s = ST_EMIT;
            end
            ST_EMIT_LI2: begin
                if (out_ready) begin
                    insn_n_s  = pend_r;
                    addr_n_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_n_s = ST_EMIT;
                end
                else state_n_s = ST_EMIT_LI2;
            end
            default: begin
                state_n_s = ST_IDLE;
                valid_n_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            insn_r  <= 32'd0;
            pend_r  <= 32'd0;
            addr_r  <= BASE_ADDR;
            err_r   <= 1'b0;
            ready_r <= 1'b1;
        end
        else begin
            state_r <= state_n_s;
            valid_r <= valid_n_s;
            insn_r  <= insn_n_s;
            pend_r  <= pend_n_s;
            addr_r  <= addr_n_s;
            err_r   <= err_n_s;
            ready_r <= (state_n_s == ST_IDLE);
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_insn  = insn_r;
    assign out_addr  = addr_r;
    assign err       = err_r;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed-vector bench for insn_encoder; a second instance with a 2-bit address checks wrap-around.
module tb_insn_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_kind = 4'd0;
    logic [3:0]  in_alu = 4'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;

    logic        in_ready, out_valid, err;
    logic [31:0] out_insn;
    logic [9:0]  out_addr;
    logic        in_ready_b, out_valid_b, err_b;
    logic [31:0] out_insn_b;
    logic [1:0]  out_addr_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    insn_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_alu(in_alu), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_insn(out_insn), .out_addr(out_addr), .err(err)
    );

    insn_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_kind(in_kind), .in_alu(in_alu), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_insn(out_insn_b), .out_addr(out_addr_b), .err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [3:0] k, input logic [3:0] a, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
        @(negedge clk);
        in_kind = k; in_alu = a; in_funct3 = f3; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        check_eq("req_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic get(input string tag, input logic [31:0] exp_insn, input logic [9:0] exp_addr);
        logic [1:0] exp_b;
        exp_b = exp_addr[1:0];
        @(negedge clk);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_insn"}, out_insn, exp_insn);
        check_eq({tag, "_addr"}, {22'd0, out_addr}, {22'd0, exp_addr});
        check_eq({tag, "_addr_w2"}, {30'd0, out_addr_b}, {30'd0, exp_b});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_insn", out_insn, 32'd0);
        check_eq("rst_addr", {22'd0, out_addr}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);

        req(4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        check_eq("add_latency", {31'd0, out_valid}, 32'd1);
        check_eq("add_busy", {31'd0, in_ready}, 32'd0);
        get("add", 32'h002081B3, 10'd0);

        req(4'd1, 4'd7, 3'd0, 5'd2, 5'd2, 5'd0, 32'd3);
        get("srai", 32'h40315113, 10'd1);

        req(4'd1, 4'd5, 3'd0, 5'd2, 5'd2, 5'd0, 32'd32);
        @(negedge clk);
        check_eq("sll32_err", {31'd0, err}, 32'd1);
        check_eq("sll32_valid", {31'd0, out_valid}, 32'd0);
        check_eq("sll32_ready", {31'd0, in_ready}, 32'd1);
        check_eq("sll32_addr", {22'd0, out_addr}, 32'd2);

        req(4'd10, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("li_hold_insn", out_insn, 32'h123462B7);
            check_eq("li_hold_addr", {22'd0, out_addr}, 32'd2);
            check_eq("li_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        get("li_lui", 32'h123462B7, 10'd2);
        @(negedge clk);
        check_eq("li_mid_ready", {31'd0, in_ready}, 32'd0);
        get("li_addi", 32'hFFF28293, 10'd3);
        @(negedge clk);
        check_eq("li_done_ready", {31'd0, in_ready}, 32'd1);

        req(4'd10, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFB);
        get("li_small", 32'hFFB00093, 10'd4);

        req(4'd9, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        get("ebreak", 32'h00100073, 10'd5);

        req(4'd3, 4'd0, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8);
        get("sw", 32'h00512423, 10'd6);

        req(4'd4, 4'd0, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        get("beq", 32'hFE208EE3, 10'd7);

        req(4'd7, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        get("jal", 32'h008000EF, 10'd8);

        req(4'd5, 4'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'hABCDE123);
        get("lui", 32'hABCDE537, 10'd9);

        req(4'd10, 4'd0, 3'd0, 5'd7, 5'd0, 5'd0, 32'h00005000);
        get("li_luionly", 32'h000053B7, 10'd10);
        @(negedge clk);
        check_eq("li_luionly_idle", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while the LUI of a two-word LI is still waiting
        req(4'd10, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_addr", {22'd0, out_addr}, 32'd0);
        check_eq("arst_addr_w2", {30'd0, out_addr_b}, 32'd0);
        check_eq("arst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        req(4'd3, 4'd0, 3'b011, 5'd0, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        check_eq("sd_err", {31'd0, err}, 32'd1);
        check_eq("sd_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
